// File: rtl/car_slot_writer_pkg.sv
// Shared types and slot address constants for the car sprite slot writer.
// Optional build macro: CAR_WRAP_EN (positions wrap instead of clamping).
package car_pkg;

    localparam int SLOT_AW = 14;

    localparam logic       RAM_SEL    = 1'b0;
    localparam logic       REG_SEL    = 1'b1;
    localparam logic [1:0] REG_BYPASS = 2'b00;
    localparam logic [1:0] REG_X0     = 2'b01;
    localparam logic [1:0] REG_Y0     = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_BYP,
        WR_X,
        WR_Y,
        LOAD
    } state_t;

    function automatic logic [SLOT_AW-1:0] reg_addr(input logic [1:0] sel);
        return {REG_SEL, {(SLOT_AW-3){1'b0}}, sel};
    endfunction

endpackage

// File: rtl/car_slot_writer_frame_tick_gen.sv
// Registered start-of-vertical-blanking pulse: high for one cycle after the
// frame counter is seen at column 0 of row V_MAX.
module frame_tick_gen #(
    parameter int V_MAX = 480
)(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    output logic        o_tick
);

    logic r_tick;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= (i_x == 11'd0) && (i_y == 11'(V_MAX));
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/car_slot_writer.sv
// Slot-bus initiator for the car sprite core: uploads a 32x32 bitmap from a
// pixel stream and rewrites bypass/x0/y0 once per frame. Build macro CAR_WRAP_EN.
module car_slot_writer
    import car_pkg::*;
#(
    parameter int CD         = 12,
    parameter int ADDR_WIDTH = 10,
    parameter int H_MAX      = 640,
    parameter int V_MAX      = 480,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic               load_start,
    input  logic               pix_valid,
    input  logic [CD-1:0]      pix_data,
    output logic               pix_ready,
    input  logic               move_en,
    input  logic [3:0]         dx,
    input  logic [3:0]         dy,
    input  logic               hide,
    output logic               busy,
    output logic               cs,
    output logic               write,
    output logic [SLOT_AW-1:0] addr,
    output logic [31:0]        wr_data,
    output logic [10:0]        x0_cur,
    output logic [10:0]        y0_cur
);

    localparam int                     PAD_W    = SLOT_AW - 1 - ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  LAST_PIX = ADDR_WIDTH'(SPRITE_W * SPRITE_H - 1);
    localparam logic signed [11:0]     X_LIM    = 12'(H_MAX - SPRITE_W);
    localparam logic signed [11:0]     Y_LIM    = 12'(V_MAX - SPRITE_H);

    state_t                r_state;
    logic                  r_pend_tick;
    logic                  r_pend_load;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [10:0]           r_x0;
    logic [10:0]           r_y0;
    logic                  r_cs;
    logic                  r_write;
    logic [SLOT_AW-1:0]    r_addr;
    logic [31:0]           r_wdata;

    logic                  w_tick;
    logic [10:0]           w_x_next;
    logic [10:0]           w_y_next;

    // Origin plus signed step, evaluated 12 bits wide so underflow is visible.
    function automatic logic [10:0] step_pos(input logic [10:0]        cur,
                                             input logic [3:0]         step,
                                             input logic signed [11:0] lim);
        logic signed [11:0] sum;
        logic [10:0]        res;
        sum = $signed({1'b0, cur}) + $signed({{8{step[3]}}, step});
`ifdef CAR_WRAP_EN
        if (sum > lim)
            res = '0;
        else if (sum < 0)
            res = lim[10:0];
        else
            res = sum[10:0];
`else
        if (sum > lim)
            res = lim[10:0];
        else if (sum < 0)
            res = '0;
        else
            res = sum[10:0];
`endif
        return res;
    endfunction

    frame_tick_gen #(
        .V_MAX (V_MAX)
    ) u_tick (
        .i_clk   (clk),
        .i_reset (reset),
        .i_x     (x),
        .i_y     (y),
        .o_tick  (w_tick)
    );

    assign w_x_next = step_pos(r_x0, dx, X_LIM);
    assign w_y_next = step_pos(r_y0, dy, Y_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pend_tick <= 1'b0;
            r_pend_load <= 1'b0;
            r_cnt       <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_cs        <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_cs    <= 1'b0;
            r_write <= 1'b0;

            // Requests that cannot be served now are remembered for the next IDLE.
            if (r_state != IDLE && w_tick)
                r_pend_tick <= 1'b1;
            if ((r_state == WR_BYP || r_state == WR_X || r_state == WR_Y) && load_start)
                r_pend_load <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_tick || r_pend_tick) begin
                        r_state     <= WR_BYP;
                        r_pend_tick <= 1'b0;
                        if (load_start)
                            r_pend_load <= 1'b1;
                        if (move_en) begin
                            r_x0 <= w_x_next;
                            r_y0 <= w_y_next;
                        end
                        r_cs    <= 1'b1;
                        r_write <= 1'b1;
                        r_addr  <= reg_addr(REG_BYPASS);
                        r_wdata <= {31'b0, hide};
                    end else if (load_start || r_pend_load) begin
                        r_state     <= LOAD;
                        r_pend_load <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                WR_BYP: begin
                    r_state <= WR_X;
                    r_cs    <= 1'b1;
                    r_write <= 1'b1;
                    r_addr  <= reg_addr(REG_X0);
                    r_wdata <= {21'b0, r_x0};
                end
                WR_X: begin
                    r_state <= WR_Y;
                    r_cs    <= 1'b1;
                    r_write <= 1'b1;
                    r_addr  <= reg_addr(REG_Y0);
                    r_wdata <= {21'b0, r_y0};
                end
                WR_Y: begin
                    r_state <= IDLE;
                end
                LOAD: begin
                    if (pix_valid) begin
                        r_cs    <= 1'b1;
                        r_write <= 1'b1;
                        r_addr  <= {RAM_SEL, {PAD_W{1'b0}}, r_cnt};
                        r_wdata <= {{(32-CD){1'b0}}, pix_data};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == LAST_PIX)
                            r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pix_ready = (r_state == LOAD);
    assign busy      = (r_state != IDLE);
    assign cs        = r_cs;
    assign write     = r_write;
    assign addr      = r_addr;
    assign wr_data   = r_wdata;
    assign x0_cur    = r_x0;
    assign y0_cur    = r_y0;

endmodule
